vga_rect_engine: RTL and testbench

Parametrised rectangle drawing engine for the VGA path: it accepts rectangle draw requests through a valid/ready handshake and buffers them in a small FIFO. It streams one pixel per clock on an x/y/colour/plot interface that connects directly to `vga_adapter`. It supports solid fill and outline modes, clips to a configurable screen size, and replaces hand-written per-shape counters in the display controllers, such as the piano key and ADSR bar drawing.

---
 rtl/vga_rect_engine.sv | 169 ++++++++++++++++
 tb/tb_vga_rect_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_engine.sv
// Rectangle drawing engine: queued draw requests are rasterised one pixel per
// clock onto the x/y/colour/plot interface of vga_adapter, with screen clipping.
module vga_rect_engine #(
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iReqValid,
  output logic                   oReqReady,
  input  logic [X_BITS-1:0]      iX0,
  input  logic [Y_BITS-1:0]      iY0,
  input  logic [X_BITS-1:0]      iW,
  input  logic [Y_BITS-1:0]      iH,
  input  logic [COLOUR_BITS-1:0] iColour,
  input  logic                   iMode,
  output logic [X_BITS-1:0]      oX,
  output logic [Y_BITS-1:0]      oY,
  output logic [COLOUR_BITS-1:0] oColour,
  output logic                   oPlot,
  output logic                   oBusy,
  output logic                   oDone
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(X_MAX);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(Y_MAX);

  typedef struct packed {
    logic [X_BITS-1:0]      x0;
    logic [Y_BITS-1:0]      y0;
    logic [X_BITS-1:0]      w;
    logic [Y_BITS-1:0]      h;
    logic [COLOUR_BITS-1:0] colour;
    logic                   mode;
  } req_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t state, next_state;

  req_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop, ready_en;

  req_t            cur;
  logic [X_BITS:0] cx, nxt_cx, last_x, x0_ext;
  logic [Y_BITS:0] cy, nxt_cy, last_y, y0_ext;
  logic            interior, on_screen, draw_pix;

  // FIFO_DEPTH is a power of two, so the count MSB alone marks full
  assign full      = count[PTR_W];
  assign empty     = (count == '0);
  assign oReqReady = ready_en & ~full;
  assign push      = iReqValid & oReqReady;
  assign oBusy     = (state != IDLE) || !empty;

  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wr_ptr] <= '{x0: iX0, y0: iY0, w: iW, h: iH, colour: iColour, mode: iMode};
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // End coordinates carry one extra bit so a rectangle past the edge never wraps
  assign x0_ext    = {1'b0, cur.x0};
  assign y0_ext    = {1'b0, cur.y0};
  assign last_x    = x0_ext + {1'b0, cur.w} - (X_BITS+1)'(1);
  assign last_y    = y0_ext + {1'b0, cur.h} - (Y_BITS+1)'(1);
  assign interior  = (cy != y0_ext) && (cy != last_y);
  assign on_screen = (cx < X_LIM) && (cy < Y_LIM);
  assign draw_pix  = (state == DRAW) && on_screen;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    nxt_cx     = cx;
    nxt_cy     = cy;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        nxt_cx     = x0_ext;
        nxt_cy     = y0_ext;
        next_state = (cur.w == '0 || cur.h == '0) ? DONE : DRAW;
      end
      DRAW: begin
        if (cx == last_x) begin
          if (cy == last_y) begin
            next_state = DONE;
          end else begin
            nxt_cx = x0_ext;
            nxt_cy = cy + (Y_BITS+1)'(1);
          end
        end else if (cur.mode && interior && cx == x0_ext) begin
          nxt_cx = last_x;
        end else begin
          nxt_cx = cx + (X_BITS+1)'(1);
        end
      end
      DONE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      cur     <= '0;
      cx      <= '0;
      cy      <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      cx    <= nxt_cx;
      cy    <= nxt_cy;
      oPlot <= draw_pix;
      oDone <= (state == DONE);
      // Coordinates only update on visible pixels, so clipped ones never show
      if (draw_pix) begin
        oX      <= cx[X_BITS-1:0];
        oY      <= cy[Y_BITS-1:0];
        oColour <= cur.colour;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_engine.sv
// Self-checking bench for vga_rect_engine: pixel scoreboard plus timing vectors.
module tb_vga_rect_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       iReqValid;
  logic       oReqReady;
  logic [7:0] iX0, iW, oX;
  logic [6:0] iY0, iH, oY;
  logic [2:0] iColour, oColour;
  logic       iMode, oPlot, oBusy, oDone;

  always #5 clk = ~clk;

  vga_rect_engine #(
    .X_BITS(8), .Y_BITS(7), .COLOUR_BITS(3),
    .X_MAX(160), .Y_MAX(120), .FIFO_DEPTH(4)
  ) dut (
    .iClock(clk), .iReset(rst), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH), .iColour(iColour), .iMode(iMode),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  typedef struct { int x0; int y0; int w; int h; int colour; int mode; } req_t;
  typedef struct { int id; int x; int y; int c; } pix_t;
  typedef struct { req_t r; int plots; int cycles; } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   plot_count = 0;
  int   done_count = 0;
  int   next_id = 0;
  pix_t pix_q[$];
  int   id_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic req_t mk(input int x0, input int y0, input int w, input int h,
                              input int c, input int m);
    req_t r;
    r.x0 = x0; r.y0 = y0; r.w = w; r.h = h; r.colour = c; r.mode = m;
    return r;
  endfunction

  function automatic vec_t mkv(input req_t r, input int plots, input int cycles);
    vec_t v;
    v.r = r; v.plots = plots; v.cycles = cycles;
    return v;
  endfunction

  // Reference pixel set: outline = cells on the rectangle border, then clip
  function automatic void push_model(input req_t r);
    for (int yy = 0; yy < r.h; yy++) begin
      for (int xx = 0; xx < r.w; xx++) begin
        if (r.mode == 0 || yy == 0 || yy == r.h - 1 || xx == 0 || xx == r.w - 1) begin
          pix_t p;
          p.id = next_id; p.x = r.x0 + xx; p.y = r.y0 + yy; p.c = r.colour;
          if (p.x < 160 && p.y < 120) pix_q.push_back(p);
        end
      end
    end
    id_q.push_back(next_id);
    next_id++;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (oPlot) begin
        plot_count++;
        if (pix_q.size() == 0) begin
          check("unexpected_plot", 1, 0);
        end else begin
          pix_t p;
          p = pix_q.pop_front();
          check("pix_x", 32'(oX), p.x);
          check("pix_y", 32'(oY), p.y);
          check("pix_colour", 32'(oColour), p.c);
        end
      end
      if (oDone) begin
        done_count++;
        if (id_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int id;
          int left;
          id = id_q.pop_front();
          left = (pix_q.size() > 0 && pix_q[0].id == id) ? 1 : 0;
          check("done_after_last_pixel", left, 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive a request, wait for acceptance, then scramble inputs to prove latching
  task automatic send(input req_t r);
    int n = 0;
    iReqValid = 1'b1;
    iX0 = 8'(r.x0); iY0 = 7'(r.y0); iW = 8'(r.w); iH = 7'(r.h);
    iColour = 3'(r.colour); iMode = 1'(r.mode);
    while (!oReqReady && n < 1000) begin
      tick();
      n++;
    end
    if (!oReqReady) begin
      check("req_accept_timeout", 0, 1);
      iReqValid = 1'b0;
    end else begin
      push_model(r);
      tick();
      iReqValid = 1'b0;
      iX0 = '1; iY0 = '1; iW = '1; iH = '1; iColour = '1; iMode = ~iMode;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int p0;
    int got;
    send(v.r);
    p0  = plot_count;
    got = -1;
    for (int k = 0; k < 600; k++) begin
      if (oDone) begin
        got = k;
        break;
      end
      tick();
    end
    check($sformatf("vec%0d_done_cycle", idx), got, 3 + v.cycles);
    check($sformatf("vec%0d_plot_count", idx), plot_count - p0, v.plots);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    req_t fr[5];
    int   gap_n[5];
    int   dk[5];
    int   ndone;
    int   prev_ready;
    int   n;
    int   p0;
    int   d0;

    vecs[0]  = mkv(mk(0, 0, 4, 4, 2, 1), 12, 12);
    vecs[1]  = mkv(mk(158, 5, 4, 1, 7, 0), 2, 4);
    vecs[2]  = mkv(mk(5, 5, 0, 3, 1, 0), 0, 0);
    vecs[3]  = mkv(mk(5, 5, 3, 0, 1, 0), 0, 0);
    vecs[4]  = mkv(mk(20, 10, 1, 4, 3, 1), 4, 4);
    vecs[5]  = mkv(mk(30, 30, 3, 2, 4, 1), 6, 6);
    vecs[6]  = mkv(mk(10, 118, 2, 4, 6, 0), 4, 8);
    vecs[7]  = mkv(mk(100, 50, 5, 3, 1, 1), 12, 12);
    vecs[8]  = mkv(mk(255, 126, 2, 2, 6, 0), 0, 4);
    vecs[9]  = mkv(mk(157, 0, 5, 3, 2, 1), 7, 12);
    vecs[10] = mkv(mk(40, 40, 2, 5, 5, 1), 10, 10);

    rst = 1'b1;
    iReqValid = 1'b0;
    iX0 = '0; iY0 = '0; iW = '0; iH = '0; iColour = '0; iMode = 1'b0;

    tick();
    tick();
    check("rst_plot", oPlot, 0);
    check("rst_done", oDone, 0);
    check("rst_busy", oBusy, 0);
    check("rst_x", 32'(oX), 0);
    check("rst_y", 32'(oY), 0);
    check("rst_colour", 32'(oColour), 0);
    check("rst_ready", oReqReady, 0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", oReqReady, 0);
    tick();
    check("ready_after_release", oReqReady, 1);
    check("busy_after_release", oBusy, 0);

    // First-pixel latency and oDone placement for a 3x2 fill
    send(mk(10, 20, 3, 2, 5, 0));
    for (int k = 0; k < 11; k++) begin
      check($sformatf("lat_plot_c%0d", k), oPlot, (k >= 3 && k <= 8));
      check($sformatf("lat_done_c%0d", k), oDone, (k == 9));
      if (k == 0)  check("lat_busy_running", oBusy, 1);
      if (k == 10) check("lat_busy_idle", oBusy, 0);
      tick();
    end

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Five back-to-back requests against a four-entry FIFO
    fr[0] = mk(20, 40, 10, 3, 3, 0);  gap_n[0] = 30;
    fr[1] = mk(0, 100, 4, 3, 6, 1);   gap_n[1] = 10;
    fr[2] = mk(150, 110, 2, 2, 1, 0); gap_n[2] = 4;
    fr[3] = mk(7, 7, 0, 5, 2, 0);     gap_n[3] = 0;
    fr[4] = mk(159, 119, 1, 1, 4, 0); gap_n[4] = 1;
    for (int i = 0; i < 5; i++) begin
      dk[i] = 0;
      send(fr[i]);
    end
    check("ready_low_when_full", oReqReady, 0);
    ndone = 0;
    prev_ready = 32'(oReqReady);
    for (int k = 0; k < 1000 && ndone < 5; k++) begin
      tick();
      if (oDone) begin
        if (ndone == 0) begin
          check("ready_before_pop", prev_ready, 0);
          check("ready_after_pop", oReqReady, 1);
        end
        dk[ndone] = k;
        ndone++;
      end
      prev_ready = 32'(oReqReady);
    end
    check("fifo_all_done", ndone, 5);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("fifo_gap%0d", i), dk[i] - dk[i-1], gap_n[i] + 2);
    end
    tick();

    // Reset in the middle of a rectangle with two more queued
    send(mk(30, 60, 10, 3, 1, 0));
    send(mk(50, 60, 3, 3, 2, 0));
    send(mk(70, 60, 3, 3, 3, 1));
    n = 0;
    while (!oPlot && n < 50) begin
      tick();
      n++;
    end
    check("midrst_saw_plot", oPlot, 1);
    rst = 1'b1;
    #1;
    check("midrst_plot", oPlot, 0);
    check("midrst_done", oDone, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_x", 32'(oX), 0);
    check("midrst_y", 32'(oY), 0);
    check("midrst_colour", 32'(oColour), 0);
    check("midrst_ready", oReqReady, 0);
    pix_q.delete();
    id_q.delete();
    tick();
    tick();
    rst = 1'b0;
    p0 = plot_count;
    d0 = done_count;
    tick();
    check("midrst_ready_after", oReqReady, 1);
    check("midrst_busy_after", oBusy, 0);
    repeat (20) tick();
    check("midrst_no_plots", plot_count - p0, 0);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_busy_idle", oBusy, 0);

    check("pixels_drained", pix_q.size(), 0);
    check("dones_drained", id_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
